// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_pkg;

  localparam int IF_XLEN = 32;

  localparam logic [IF_XLEN-1:0] NOP = '0;

  typedef struct packed {
    logic [IF_XLEN-1:0] instr;
    logic [IF_XLEN-1:0] pcplus4;
  } fetch_entry_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Circular FIFO for fetched entries; DEPTH must be a power of two so the
// pointers wrap naturally.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC generation, credit-limited imem requests and a
// decoupling queue to ID. Interrupt redirect is built only with IF_INTERRUPT_EN.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int               XLEN       = IF_XLEN,
  parameter int               DEPTH      = 4,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter logic [XLEN-1:0]  INT_VECTOR = 32'h8000_0004
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            interrupt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pcplus4,
  output logic            int_taken,
  output logic [XLEN-1:0] int_epc
);

  localparam int CW = cnt_width(DEPTH);
  // Stale responses accumulate across back-to-back redirects, so give headroom.
  localparam int SW = CW + 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pcplus4;
  } entry_t;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   outst_q;
  logic [SW-1:0]   stale_q;
  logic [CW-1:0]   count;
  logic            empty;
  entry_t          head;
  entry_t          wdata;
  logic            take_int;
  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic            credit;
  logic            fire;
  logic            resp_live;
  logic            push;
  logic            pop;

  assign flush    = redirect_valid | take_int;
  assign flush_pc = redirect_valid ? redirect_pc : INT_VECTOR;

  assign credit    = ({1'b0, count} + {1'b0, outst_q}) < (CW+1)'(DEPTH);
  assign imem_req  = reset & ~flush & credit;
  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_gnt;

  assign resp_live = imem_rvalid & (stale_q == '0);
  assign push      = resp_live & ~flush;
  assign pop       = id_valid & id_ready & ~flush;
  assign wdata     = '{instr: imem_rdata, pcplus4: resp_pc_q + XLEN'(4)};

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (wdata),
    .dout  (head),
    .count (count),
    .empty (empty)
  );

  assign id_valid   = ~empty;
  assign id_instr   = id_valid ? head.instr   : XLEN'(NOP);
  assign id_pcplus4 = id_valid ? head.pcplus4 : '0;

  // resp_pc_q tracks the address of the oldest live request, since responses return in order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      stale_q   <= '0;
    end else if (flush) begin
      pc_q      <= flush_pc;
      resp_pc_q <= flush_pc;
      outst_q   <= '0;
      stale_q   <= stale_q + SW'(outst_q) - SW'(imem_rvalid);
    end else begin
      if (fire) pc_q <= pc_q + XLEN'(4);
      if (imem_rvalid) begin
        if (stale_q != '0) stale_q   <= stale_q - SW'(1);
        else               resp_pc_q <= resp_pc_q + XLEN'(4);
      end
      if (fire && !resp_live)      outst_q <= outst_q + CW'(1);
      else if (resp_live && !fire) outst_q <= outst_q - CW'(1);
    end
  end

`ifdef IF_INTERRUPT_EN
  logic armed_q;

  // Edge-armed: a held interrupt level fires once until it is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         armed_q <= 1'b1;
    else if (!interrupt) armed_q <= 1'b1;
    else if (take_int)  armed_q <= 1'b0;
  end

  assign take_int = reset & interrupt & armed_q & ~redirect_valid;
  assign int_epc  = take_int ? (id_valid ? head.pcplus4 - XLEN'(4) : pc_q) : '0;
`else
  logic unused_interrupt;
  assign unused_interrupt = interrupt;
  assign take_int = 1'b0;
  assign int_epc  = '0;
`endif

  assign int_taken = take_int;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order variable-latency memory model.
module tb_if_fetch_queue;

  localparam int          XLEN       = 32;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INT_VECTOR = 32'h8000_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        interrupt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pcplus4;
  logic        int_taken;
  logic [31:0] int_epc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } req_t;
  req_t mq[$];

  always #5 clk = ~clk;

  if_fetch_queue #(
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC),
    .INT_VECTOR (INT_VECTOR)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .interrupt      (interrupt),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pcplus4     (id_pcplus4),
    .int_taken      (int_taken),
    .int_epc        (int_epc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: responses in request order, mem_lat cycles after the grant cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!reset) begin
        mq.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(mq[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
      @(negedge clk);
      if (reset) begin
        if (imem_rvalid) void'(mq.pop_front());
        if (imem_req && imem_gnt) mq.push_back('{due: cyc + mem_lat, addr: imem_addr});
      end
    end
  end

  always @(negedge clk) begin
    if (reset && dut.u_fifo.push && !dut.u_fifo.pop && dut.u_fifo.count == 3'(DEPTH)) begin
      failures++;
      $display("FAIL fifo_overflow: push into full queue at cycle %0d", cyc);
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 after release, inputs set for that cycle.
  task automatic restart(input int lat, input logic rdy);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    interrupt      = 1'b0;
    mem_lat        = lat;
    id_ready       = rdy;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({imem_req, id_valid, int_taken} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got req/valid/int=%b required 000", {imem_req, id_valid, int_taken});
    end
    checks++;
    if (imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL reset_addr: got %h required %h", imem_addr, RESET_PC);
    end
    checks++;
    if ({id_instr, id_pcplus4, int_epc} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: got instr=%h pcplus4=%h epc=%h required zeros", id_instr, id_pcplus4, int_epc);
    end
  endtask

  task automatic test_stream;
    restart(1, 1'b1);
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4*n)) begin
        failures++;
        $display("FAIL stream_req[%0d]: got req=%b addr=%h required 1 %h", n, imem_req, imem_addr, 32'(4*n));
      end
      checks++;
      if (n < 2) begin
        if (id_valid !== 1'b0) begin
          failures++;
          $display("FAIL stream_early_valid[%0d]: got %b required 0", n, id_valid);
        end
      end else if (id_valid !== 1'b1 || id_pcplus4 !== 32'(4*(n-1)) || id_instr !== instr_of(32'(4*(n-2)))) begin
        failures++;
        $display("FAIL stream_id[%0d]: got v=%b pc4=%h instr=%h required 1 %h %h", n, id_valid, id_pcplus4,
                 id_instr, 32'(4*(n-1)), instr_of(32'(4*(n-2))));
      end
    end
  endtask

  task automatic test_stall;
    int grants;
    restart(1, 1'b0);
    grants = 0;
    repeat (12) begin
      @(negedge clk);
      if (imem_req && imem_gnt) grants++;
    end
    checks++;
    if (grants !== DEPTH) begin
      failures++;
      $display("FAIL stall_grants: got %0d required %0d", grants, DEPTH);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h10) begin
      failures++;
      $display("FAIL stall_hold: got req=%b addr=%h required 0 00000010", imem_req, imem_addr);
    end
    checks++;
    if (id_valid !== 1'b1 || id_pcplus4 !== 32'h4) begin
      failures++;
      $display("FAIL stall_head: got v=%b pc4=%h required 1 00000004", id_valid, id_pcplus4);
    end
    next_cycle();
    id_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (id_valid !== 1'b1 || id_pcplus4 !== 32'(4*(k+1))) begin
        failures++;
        $display("FAIL stall_drain[%0d]: got v=%b pc4=%h required 1 %h", k, id_valid, id_pcplus4, 32'(4*(k+1)));
      end
      if (k == 1) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          failures++;
          $display("FAIL stall_resume: got req=%b addr=%h required 1 00000010", imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_drop;
    restart(3, 1'b1);
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      failures++;
      $display("FAIL drop_req_in_redirect: got %b required 0", imem_req);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL drop_refetch: got req=%b addr=%h required 1 00000100", imem_req, imem_addr);
    end
    for (int c = 3; c < 7; c++) begin
      if (c > 3) @(negedge clk);
      checks++;
      if (id_valid !== 1'b0) begin
        failures++;
        $display("FAIL drop_stale_visible[c%0d]: got v=%b pc4=%h required v=0", c, id_valid, id_pcplus4);
      end
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pcplus4 !== 32'h104 || id_instr !== instr_of(32'h100)) begin
      failures++;
      $display("FAIL drop_first_new: got v=%b pc4=%h instr=%h required 1 00000104 %h", id_valid, id_pcplus4,
               id_instr, instr_of(32'h100));
    end
  endtask

  task automatic test_redirect_collide;
    restart(1, 1'b1);
    next_cycle();
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pcplus4 !== 32'h8) begin
      failures++;
      $display("FAIL collide_pre: got req=%b v=%b pc4=%h required 0 1 00000008", imem_req, id_valid, id_pcplus4);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL collide_post: got v=%b req=%b addr=%h required 0 1 00000200", id_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_gap: got v=%b pc4=%h required v=0", id_valid, id_pcplus4);
    end
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pcplus4 !== 32'h204) begin
      failures++;
      $display("FAIL collide_new: got v=%b pc4=%h required 1 00000204", id_valid, id_pcplus4);
    end
  endtask

  task automatic test_interrupt;
    int pulses;
    restart(1, 1'b0);
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    next_cycle();
    redirect_valid = 1'b0;
    repeat (4) next_cycle();
    interrupt = 1'b1;
    pulses = 0;
    @(negedge clk);
    if (int_taken) pulses++;
`ifdef IF_INTERRUPT_EN
    checks++;
    if (int_taken !== 1'b1 || int_epc !== 32'h1C || id_pcplus4 !== 32'h20 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL int_fire: got taken=%b epc=%h pc4=%h req=%b required 1 0000001c 00000020 0", int_taken,
               int_epc, id_pcplus4, imem_req);
    end
    @(negedge clk);
    if (int_taken) pulses++;
    checks++;
    if (imem_addr !== INT_VECTOR || id_valid !== 1'b0) begin
      failures++;
      $display("FAIL int_vector: got addr=%h v=%b required %h 0", imem_addr, id_valid, INT_VECTOR);
    end
    repeat (3) begin
      @(negedge clk);
      if (int_taken) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL int_once: got %0d pulses required 1", pulses);
    end
`else
    checks++;
    if (int_taken !== 1'b0 || int_epc !== 32'h0 || id_pcplus4 !== 32'h20) begin
      failures++;
      $display("FAIL int_disabled: got taken=%b epc=%h pc4=%h required 0 00000000 00000020", int_taken, int_epc,
               id_pcplus4);
    end
    repeat (3) begin
      @(negedge clk);
      if (int_taken) pulses++;
    end
    checks++;
    if (pulses !== 0 || imem_addr === INT_VECTOR || id_valid !== 1'b1) begin
      failures++;
      $display("FAIL int_ignored: got pulses=%0d addr=%h v=%b required 0 not-vector 1", pulses, imem_addr, id_valid);
    end
`endif
    interrupt = 1'b0;
  endtask

  task automatic test_reset_midburst;
    restart(1, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, id_valid, int_taken} !== 3'b000 || imem_addr !== RESET_PC) begin
      failures++;
      $display("FAIL midreset_async: got req=%b v=%b int=%b addr=%h required 0 0 0 %h", imem_req, id_valid,
               int_taken, imem_addr, RESET_PC);
    end
    checks++;
    if ({id_instr, id_pcplus4, int_epc} !== 96'h0) begin
      failures++;
      $display("FAIL midreset_data: got instr=%h pc4=%h epc=%h required zeros", id_instr, id_pcplus4, int_epc);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || id_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_restart: got req=%b addr=%h v=%b required 1 %h 0", imem_req, imem_addr, id_valid,
               RESET_PC);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pcplus4 !== 32'h4) begin
      failures++;
      $display("FAIL midreset_first: got v=%b pc4=%h required 1 00000004", id_valid, id_pcplus4);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_collide();
    test_interrupt();
    test_reset_midburst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
